// File: rtl/stream_mux4x1.sv
// Four-channel valid/ready merge with round-robin arbitration and one registered
// output stage; sel_o reports which channel supplied the beat on y_o.
module stream_mux4x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] x0_i,
    input  logic [WIDTH-1:0] x1_i,
    input  logic [WIDTH-1:0] x2_i,
    input  logic [WIDTH-1:0] x3_i,
    input  logic [3:0]       valid_i,
    output logic [3:0]       ready_o,
    output logic [WIDTH-1:0] y_o,
    output logic [1:0]       sel_o,
    output logic             valid_o,
    input  logic             ready_i
);

    logic [WIDTH-1:0] r_y;
    logic [1:0]       r_sel;
    logic             r_valid;
    logic [1:0]       r_ptr;

    logic             w_load_en;
    logic             w_found;
    logic [1:0]       w_grant;
    logic [1:0]       w_idx;
    logic [WIDTH-1:0] w_x;

    assign w_load_en = !r_valid || ready_i;

    // First requesting channel at or after the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && valid_i[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        case (w_grant)
            2'd0:    w_x = x0_i;
            2'd1:    w_x = x1_i;
            2'd2:    w_x = x2_i;
            default: w_x = x3_i;
        endcase
    end

    assign ready_o = (w_load_en && w_found && !rst_i) ? (4'b0001 << w_grant) : 4'b0000;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_y     <= '0;
            r_sel   <= 2'd0;
            r_valid <= 1'b0;
            r_ptr   <= 2'd0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_y     <= w_x;
                r_sel   <= w_grant;
                r_valid <= 1'b1;
                r_ptr   <= w_grant + 2'd1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign y_o     = r_y;
    assign sel_o   = r_sel;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_stream_mux4x1.sv
// Directed bench for stream_mux4x1: expected beats go into a queue at grant time
// and a monitor pops them whenever the output beat is consumed.
module tb_stream_mux4x1;
    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [WIDTH-1:0] x0_i, x1_i, x2_i, x3_i;
    logic [3:0]       valid_i;
    logic [3:0]       ready_o;
    logic [WIDTH-1:0] y_o;
    logic [1:0]       sel_o;
    logic             valid_o;
    logic             ready_i;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH+1:0] exp_q[$];

    stream_mux4x1 #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .x0_i    (x0_i),
        .x1_i    (x1_i),
        .x2_i    (x2_i),
        .x3_i    (x3_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .y_o     (y_o),
        .sel_o   (sel_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Expect channel ch to be granted this cycle with data d.
    task automatic grant(input string nm, input logic [1:0] ch, input logic [7:0] d);
        #1;
        chk(nm, 32'(ready_o), 32'(4'b0001 << ch));
        exp_q.push_back({ch, d});
    endtask

    // A beat is consumed at the next edge whenever valid_o && ready_i.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat: got sel=%0d y=%0h expected no beat", sel_o, y_o);
            end else begin
                logic [WIDTH+1:0] e;
                e = exp_q.pop_front();
                if ({sel_o, y_o} !== e) begin
                    n_err++;
                    $display("FAIL beat: got sel=%0d y=%0h expected sel=%0d y=%0h",
                             sel_o, y_o, e[WIDTH+1:WIDTH], e[WIDTH-1:0]);
                end
            end
        end
    end

    initial begin
        logic [7:0] dat [4];
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
        rst_i = 1'b1; valid_i = 4'b1111; ready_i = 1'b0;
        x0_i = 8'h11; x1_i = 8'h22; x2_i = 8'h33; x3_i = 8'h44;

        // Reset held two edges with all channels requesting
        step(); step();
        chk("rst_ready", 32'(ready_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_y", 32'(y_o), 32'h0);
        chk("rst_sel", 32'(sel_o), 32'h0);
        rst_i = 1'b0;

        // Round robin, no bubbles
        ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            grant("rr_ready", 2'(k % 4), dat[k % 4]);
            step();
            chk("rr_valid", 32'(valid_o), 32'h1);
        end

        // Single channel 2 with new data
        valid_i = 4'b0100; x2_i = 8'hA5;
        grant("single_ready", 2'd2, 8'hA5);
        step();
        chk("single_y", 32'(y_o), 32'hA5);
        chk("single_sel", 32'(sel_o), 32'h2);
        chk("single_valid", 32'(valid_o), 32'h1);
        valid_i = 4'b0000; x2_i = 8'h33;
        step();
        chk("single_drop", 32'(valid_o), 32'h0);

        // ptr is 3: channel 3 grant brings it back to 0
        valid_i = 4'b1000;
        grant("c3_ready", 2'd3, 8'h44);
        step();

        // Backpressure after a channel-0 beat
        valid_i = 4'b1111;
        grant("bp_first", 2'd0, 8'h11);
        step();
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 32'(ready_o), 32'h0);
            step();
            chk("bp_y", 32'(y_o), 32'h11);
            chk("bp_sel", 32'(sel_o), 32'h0);
            chk("bp_valid", 32'(valid_o), 32'h1);
        end
        ready_i = 1'b1;
        grant("bp_next", 2'd1, 8'h22);
        step();

        // Wrap from ptr 3 and skip idle channels
        valid_i = 4'b0100;
        grant("wrap_c2", 2'd2, 8'h33);
        step();
        valid_i = 4'b0011;
        grant("wrap_c0", 2'd0, 8'h11);
        step();
        grant("wrap_c1", 2'd1, 8'h22);
        step();
        valid_i = 4'b1000;
        grant("skip_c3", 2'd3, 8'h44);
        step();
        valid_i = 4'b0000;
        step();
        chk("idle_valid", 32'(valid_o), 32'h0);

        // Mid-stream reset discards a stalled beat (not queued)
        valid_i = 4'b0010;
        #1;
        chk("mr_ready", 32'(ready_o), 32'h2);
        step();
        ready_i = 1'b0; valid_i = 4'b1111;
        chk("mr_pending", 32'(valid_o), 32'h1);
        rst_i = 1'b1;
        #1;
        chk("mr_rst_ready", 32'(ready_o), 32'h0);
        step();
        rst_i = 1'b0;
        chk("mr_valid", 32'(valid_o), 32'h0);
        chk("mr_y", 32'(y_o), 32'h0);
        chk("mr_sel", 32'(sel_o), 32'h0);
        ready_i = 1'b1;
        grant("mr_ptr0", 2'd0, 8'h11);
        step();
        valid_i = 4'b0000;
        step();
        chk("mr_end_valid", 32'(valid_o), 32'h0);
        step();

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
